beamformer_seq: RTL
===================

// Module: beamformer_seq
// PURPOSE
//  Parametrised transmit sequencer; successor to the 8-channel fixed beamformer top. One frame
//  engine replaces three free-running sub-modules. Debounced buttons select a mode; the mode
//  changes only at a frame boundary. Emits bipolar per-channel pulses with linear steering delay.
//  Sits between board buttons/LEDs and the pulser drive pins.
// PARAMETERS
//  NCH          8      channel count (2..64)
//  DLY_W        6      width of steer_step (delay cycles per channel)
//  PULSE_LEN    4      cycles per pos phase and per neg phase
//  PRF_PERIOD   12500  frame length in clocks (10 kHz at 125 MHz)
//  LP_DIV       4      low-power mode fires one frame in LP_DIV
//  DEBOUNCE_CYC 1250   cycles a button must stay stable before acceptance
//  DEADTIME     2      idle cycles between pos and neg phase (BF_DEADTIME_EN only)
// PORTS
//  clock      in   1      system clock, 125 MHz
//  reset_n    in   1      asynchronous active-low reset
//  btn        in   4      raw buttons; [0]=NORMAL [1]=LOW_POWER [2]=TEST [3]=OFF
//  steer_step in   DLY_W  per-channel delay increment, sampled at frame start
//  posOutput  out  NCH    positive pulser drive per channel
//  negOutput  out  NCH    negative pulser drive per channel
//  led        out  4      one-hot current active mode (same bit order as btn), 0 when OFF
//  frame_sync out  1      1-cycle strobe on the first cycle of every frame
// BEHAVIOUR
//  Interface: one clock (clock); reset is asynchronous and active-low (reset_n).
//  Reset: mode=OFF, pending=OFF, all outputs 0, frame_cnt=0, lp_cnt=0, test_ch=0.
//  Debounce: per-bit 2-flop sync then counter; a bit is accepted after DEBOUNCE_CYC stable cycles.
//   Accepted press edge sets pending mode. Priority btn0>btn1>btn2>btn3 for same-cycle presses.
//  Frame counter: 0..PRF_PERIOD-1, wraps. At count 0: frame_sync=1, mode<=pending, latch steer_step
//   as step_q, led updates the same cycle. A press mid-frame never alters the current frame.
//  FSM: IDLE -> FIRE -> HOLD -> IDLE.
//   IDLE: at count 0, go to FIRE if the frame is firing, else stay in IDLE.
//   FIRE: fire_cnt runs from 0 while outputs are driven.
//   HOLD: outputs 0 until the frame wraps.
//   FIRE->HOLD when fire_cnt = (NCH-1)*step_q + 2*PULSE_LEN [+DEADTIME] - 1.
//  Firing frame rules:
//   NORMAL: every frame.
//   LOW_POWER: only when lp_cnt==0; lp_cnt increments mod LP_DIV each frame.
//   TEST: every frame.
//   OFF: never.
//  Channel i delay: NORMAL/LOW_POWER d_i = i*step_q. Width DLY_W+clog2(NCH), no truncation.
//   TEST: only channel test_ch fires, with d=0. test_ch increments each frame and wraps NCH-1->0.
//  Channel timing:
//   pos[i]=1 for fire_cnt in [d_i, d_i+PULSE_LEN).
//   neg[i]=1 for fire_cnt in [d_i+PULSE_LEN(+DEADTIME), +PULSE_LEN).
//   pos[i]&neg[i] is never 1. All outputs are registered, so pulses appear 1 cycle after fire_cnt.
//  steer_step=0: all channels fire simultaneously.
//  Elaboration $error if (NCH-1)*(2**DLY_W-1)+2*PULSE_LEN+DEADTIME+1 >= PRF_PERIOD.
//  Mode change into OFF: completes current frame, then silent. Reset mid-pulse: outputs 0 at once.
//  lp_cnt and test_ch reset to 0 when their mode is entered.
// CONFIGURATION
//  BF_DEADTIME_EN defined: DEADTIME idle cycles inserted between the pos and neg phase of each channel.
//  BF_DEADTIME_EN undefined: neg follows pos with no gap; DEADTIME is ignored.
// STRUCTURE
//  Package bf_pkg:
//   mode_t enum OFF/NORMAL/LOW_POWER/TEST (2-bit).
//   fsm_t enum IDLE/FIRE/HOLD.
//   function mode_to_led.
//  Sub-module bf_btn_debounce (one instance per button bit, parameter DEBOUNCE_CYC).
//  Channel comparators: a generate loop in this module; no per-channel sub-module.
// TESTING (sim with PRF_PERIOD=200, DEBOUNCE_CYC=8, NCH=8, PULSE_LEN=4)
//  1 reset_n=0 mid-frame -> all outputs 0 asynchronously; after release, led=0 and no pulses.
//  2 btn[0] held 8 cycles, steer_step=3 -> next frame: led=0001; pos[i] starts 3*i+1 cycles after
//    frame_sync; neg[i] follows exactly 4 cycles later; all 8 channels fire.
//  3 LOW_POWER mode -> pulses in frames 0,4,8 only; frame_sync in every frame.
//  4 TEST mode, 10 frames -> only pos[k]/neg[k] active; k=0..7 then 0,1; zero delay.
//  5 btn[1] pressed at cycle 50 of a NORMAL frame -> that frame completes in NORMAL; switch next frame.
//  6 btn[0] and btn[2] same cycle -> NORMAL wins. Assertion: pos&neg==0 on every cycle.
//    BF_DEADTIME_EN build: gap = 2 cycles.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared types and helpers for the beamformer transmit sequencer.
package bf_pkg;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    NORMAL    = 2'd1,
    LOW_POWER = 2'd2,
    TEST      = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    HOLD = 2'd2
  } fsm_t;

  // LED bit order matches the button order; OFF shows nothing.
  function automatic logic [3:0] mode_to_led(input mode_t m);
    logic [3:0] l;
    l = '0;
    case (m)
      NORMAL:    l = 4'b0001;
      LOW_POWER: l = 4'b0010;
      TEST:      l = 4'b0100;
      default:   l = 4'b0000;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/bf_btn_debounce.sv
// Single-bit button conditioner: 2-flop synchroniser, stability counter,
// and a one-cycle strobe when a new pressed level is accepted.
module bf_btn_debounce #(
  parameter int DEBOUNCE_CYC = 1250
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]       sync_q;
  logic             level_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      press_q <= 1'b0;
      // Counter only runs while the synced input disagrees with the accepted level.
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
        level_q <= sync_q[1];
        press_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/beamformer_seq.sv
// Frame-based transmit sequencer with linear steering delay and debounced mode buttons.
// Define BF_DEADTIME_EN to insert DEADTIME idle cycles between pos and neg phases.
module beamformer_seq
  import bf_pkg::*;
#(
  parameter int NCH          = 8,
  parameter int DLY_W        = 6,
  parameter int PULSE_LEN    = 4,
  parameter int PRF_PERIOD   = 12500,
  parameter int LP_DIV       = 4,
  parameter int DEBOUNCE_CYC = 1250,
  parameter int DEADTIME     = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       btn,
  input  logic [DLY_W-1:0] steer_step,
  output logic [NCH-1:0]   posOutput,
  output logic [NCH-1:0]   negOutput,
  output logic [3:0]       led,
  output logic             frame_sync
);

`ifdef BF_DEADTIME_EN
  localparam int DT = DEADTIME;
`else
  localparam int DT = 0;
`endif
  localparam int FC_W = $clog2(PRF_PERIOD);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int LP_W = (LP_DIV > 1) ? $clog2(LP_DIV) : 1;
  localparam int DW   = DLY_W + CH_W;
  localparam int CW   = ((FC_W > DW) ? FC_W : DW) + 1;

  if ((NCH - 1) * (2 ** DLY_W - 1) + 2 * PULSE_LEN + DEADTIME + 1 >= PRF_PERIOD) begin : g_chk
    $error("beamformer_seq: longest firing window does not fit in PRF_PERIOD");
  end

  logic [3:0] press;

  bf_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db [3:0] (
    .clock  (clock),
    .reset_n(reset_n),
    .btn_i  (btn),
    .press_o(press)
  );

  fsm_t             fsm_q, fsm_d;
  mode_t            mode_q, mode_d, pend_q, pend_d;
  logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CW-1:0]    fc_q, fc_d, fire_last;
  logic [DLY_W-1:0] step_q, step_d;
  logic [LP_W-1:0]  lp_q, lp_d, lp_use;
  logic [CH_W-1:0]  tch_q, tch_d;
  logic [3:0]       led_q, led_d;
  logic             fsync_q, start, fire_now;
  logic [NCH-1:0]   pos_q, neg_q, pos_d, neg_d;

  assign start     = (frame_cnt_q == '0);
  assign fire_last = CW'(NCH - 1) * CW'(step_q) + CW'(2 * PULSE_LEN + DT - 1);

  always_comb begin
    frame_cnt_d = (frame_cnt_q == FC_W'(PRF_PERIOD - 1)) ? '0 : frame_cnt_q + 1'b1;
    pend_d   = pend_q;
    mode_d   = mode_q;
    step_d   = step_q;
    lp_d     = lp_q;
    lp_use   = '0;
    tch_d    = tch_q;
    led_d    = led_q;
    fire_now = 1'b0;
    fsm_d    = fsm_q;
    fc_d     = fc_q;

    if (press[0])      pend_d = NORMAL;
    else if (press[1]) pend_d = LOW_POWER;
    else if (press[2]) pend_d = TEST;
    else if (press[3]) pend_d = OFF;

    // Frame boundary: adopt the pending mode and decide whether this frame fires.
    if (start) begin
      mode_d = pend_q;
      step_d = steer_step;
      led_d  = mode_to_led(pend_q);
      case (pend_q)
        NORMAL: fire_now = 1'b1;
        LOW_POWER: begin
          lp_use   = (mode_q != LOW_POWER) ? '0 : lp_q;
          fire_now = (lp_use == '0);
          lp_d     = (lp_use == LP_W'(LP_DIV - 1)) ? '0 : lp_use + 1'b1;
        end
        TEST: begin
          fire_now = 1'b1;
          tch_d    = (mode_q != TEST || tch_q == CH_W'(NCH - 1)) ? '0 : tch_q + 1'b1;
        end
        default: fire_now = 1'b0;
      endcase
    end

    case (fsm_q)
      IDLE: if (fire_now) begin
        fsm_d = FIRE;
        fc_d  = '0;
      end
      FIRE: if (fc_q == fire_last) fsm_d = HOLD;
            else fc_d = fc_q + 1'b1;
      HOLD: if (frame_cnt_q == FC_W'(PRF_PERIOD - 1)) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] d;
    logic          en;
    assign d  = (mode_q == TEST) ? '0 : CW'(i) * CW'(step_q);
    assign en = (fsm_q == FIRE) && ((mode_q != TEST) || (tch_q == CH_W'(i)));
    assign pos_d[i] = en && (fc_q >= d) && (fc_q < d + CW'(PULSE_LEN));
    assign neg_d[i] = en && (fc_q >= d + CW'(PULSE_LEN + DT)) && (fc_q < d + CW'(2 * PULSE_LEN + DT));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q       <= IDLE;
      mode_q      <= OFF;
      pend_q      <= OFF;
      frame_cnt_q <= '0;
      fc_q        <= '0;
      step_q      <= '0;
      lp_q        <= '0;
      tch_q       <= '0;
      led_q       <= '0;
      fsync_q     <= 1'b0;
      pos_q       <= '0;
      neg_q       <= '0;
    end else begin
      fsm_q       <= fsm_d;
      mode_q      <= mode_d;
      pend_q      <= pend_d;
      frame_cnt_q <= frame_cnt_d;
      fc_q        <= fc_d;
      step_q      <= step_d;
      lp_q        <= lp_d;
      tch_q       <= tch_d;
      led_q       <= led_d;
      fsync_q     <= start;
      pos_q       <= pos_d;
      neg_q       <= neg_d;
    end
  end

  assign posOutput  = pos_q;
  assign negOutput  = neg_q;
  assign led        = led_q;
  assign frame_sync = fsync_q;

endmodule
